// File: rtl/route_cfg_sched.sv
// Route configuration sequencer: queues {ctrl, beats, sel} entries and applies each ctrl word
// only between transfers. Optional idle-beat watchdog enabled by defining ROUTE_TIMEOUT_EN.
module route_cfg_sched #(
  parameter int CFG_DEPTH   = 4,
  parameter int CNT_W       = 16,
  parameter int SETTLE_CYC  = 2,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [35:0]      s_cfg_ctrl,
  input  logic [CNT_W-1:0] s_cfg_beats,
  input  logic [2:0]       s_cfg_sel,
  input  logic             s_cfg_tvalid,
  output logic             s_cfg_tready,
  input  logic [7:0]       out_fire,
  output logic [35:0]      ctrl,
  output logic             route_en,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int PTR_W = $clog2(CFG_DEPTH);
  localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [PTR_W:0]   DEPTH_C     = CFG_DEPTH[PTR_W:0];
  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYC - 1);

  typedef struct packed {
    logic [35:0]      ctrl;
    logic [CNT_W-1:0] beats;
    logic [2:0]       sel;
  } cfg_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SETTLE,
    S_RUN,
    S_DONE
  } state_t;

  cfg_t             mem_q [CFG_DEPTH];
  cfg_t             head;
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             push, pop;

  state_t           state_q, state_d;
  logic [35:0]      ctrl_q, ctrl_d;
  logic [CNT_W-1:0] beat_q, beat_d;
  logic [2:0]       sel_q, sel_d;
  logic [SET_W-1:0] settle_q, settle_d;
  logic             sel_fire;

  assign s_cfg_tready = (count_q != DEPTH_C);
  assign push         = s_cfg_tvalid && s_cfg_tready;
  assign pop          = (state_q == S_LOAD);
  assign head         = mem_q[rd_ptr_q];
  assign sel_fire     = out_fire[sel_q];

  // NOTE: FIFO storage has no reset; the pointers and count alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= '{ctrl: s_cfg_ctrl, beats: s_cfg_beats, sel: s_cfg_sel};
  end

  // NOTE: every clocked block uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

`ifdef ROUTE_TIMEOUT_EN
  localparam int              WD_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

  logic [WD_W-1:0] wd_q, wd_d;
  logic            err_q, err_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      ctrl_q   <= '0;
      beat_q   <= '0;
      sel_q    <= '0;
      settle_q <= '0;
    end else begin
      state_q  <= state_d;
      ctrl_q   <= ctrl_d;
      beat_q   <= beat_d;
      sel_q    <= sel_d;
      settle_q <= settle_d;
    end
  end

  // NOTE: every next-state signal gets its hold value first so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    ctrl_d   = ctrl_q;
    beat_d   = beat_q;
    sel_d    = sel_q;
    settle_d = settle_q;
`ifdef ROUTE_TIMEOUT_EN
    wd_d     = wd_q;
    err_d    = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (count_q != '0) state_d = S_LOAD;
      end
      S_LOAD: begin
        ctrl_d   = head.ctrl;
        beat_d   = head.beats;
        sel_d    = head.sel;
        settle_d = SETTLE_LAST;
`ifdef ROUTE_TIMEOUT_EN
        wd_d     = '0;
`endif
        state_d  = (head.beats == '0) ? S_DONE : S_SETTLE;
      end
      S_SETTLE: begin
        if (settle_q == '0) state_d = S_RUN;
        else                settle_d = settle_q - 1'b1;
      end
      S_RUN: begin
        if (sel_fire) begin
          beat_d = beat_q - 1'b1;
`ifdef ROUTE_TIMEOUT_EN
          wd_d   = '0;
`endif
          if (beat_q == CNT_W'(1)) state_d = S_DONE;
        end
`ifdef ROUTE_TIMEOUT_EN
        else if (wd_q == WD_LAST) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          wd_d = wd_q + 1'b1;
        end
`endif
      end
      S_DONE: begin
        // An entry accepted during DONE is already committed by the time LOAD pops it.
        state_d = ((count_q != '0) || push) ? S_LOAD : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign ctrl     = ctrl_q;
  assign route_en = (state_q == S_RUN);
  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);

endmodule
